// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Byte buffer sitting directly behind the UART receiver. Accepts bytes through
// the receiver's rx_data / rx_data_valid handshake (by driving its host_ready),
// tags every byte with the receiver's framing-error status, auto-clears that
// status once captured, and offers a first-word-fall-through read port with
// occupancy and status flags to the host register block.
//
// Optional feature (compile-time macro RX_FIFO_TIMEOUT_EN):
//   defined   -> idle counter drives rx_timeout (character timeout)
//   undefined -> no counter, rx_timeout tied low
//
// Parameters:
//   DEPTH          entry count, power of 2, 2..256
//   AFULL_LEVEL    almost_full threshold (count >= AFULL_LEVEL), 1..DEPTH
//   TIMEOUT_CYCLES idle cycles before rx_timeout (timeout build only)
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   rx_data[7:0]           receiver data
//   rx_data_valid          receiver holds a byte
//   rx_framing_err         receiver sticky framing error (level)
//   rx_overrun             receiver overrun indication (level)
//   rx_host_ready          to receiver host_ready; byte accepted when valid
//   rx_clear_framing_err   one-cycle pulse after a byte tagged with an error
//   flush                  synchronous empty request
//   rd_en                  pop head entry
//   rd_data[7:0], rd_ferr  head entry (FWFT), zero while empty
//   rd_valid               head entry valid
//   count                  occupancy
//   full, almost_full      occupancy flags
//   overrun_sticky         receiver overrun seen since last overrun_clear
//   overrun_clear          clears overrun_sticky (a coincident overrun wins)
//   rx_timeout             character-timeout flag
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int AFULL_LEVEL    = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_data_valid,
  input  logic                       rx_framing_err,
  input  logic                       rx_overrun,
  output logic                       rx_host_ready,
  output logic                       rx_clear_framing_err,
  input  logic                       flush,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       rd_ferr,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overrun_sticky,
  input  logic                       overrun_clear,
  output logic                       rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  // Elaboration-time parameter sanity checks.
  generate
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of 2 in 2..256");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("uart_rx_fifo: AFULL_LEVEL must be in 1..DEPTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("uart_rx_fifo: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [8:0]    mem [DEPTH];      // {ferr, data}
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic [8:0]    head;

  // ---------------------------------------------------------------------------
  // Handshake and flags
  // ---------------------------------------------------------------------------
  // host_ready depends only on registered count and flush, so a same-cycle pop
  // never opens a slot for a push while full. A flush also cancels any pop.
  always_comb begin
    empty         = (count == '0);
    full          = (count == DEPTH_C);
    almost_full   = (count >= AFULL_C);
    rd_valid      = ~empty;
    rx_host_ready = ~full & ~flush;
    push          = rx_data_valid & rx_host_ready;
    pop           = rd_en & ~empty & ~flush;
  end

  // FWFT read port; outputs are forced to zero while the buffer is empty so
  // stale or never-written entries are not exposed.
  always_comb begin
    head    = mem[rd_ptr];
    rd_data = '0;
    rd_ferr = 1'b0;
    if (!empty) begin
      rd_data = head[7:0];
      rd_ferr = head[8];
    end
  end

  // Data array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rx_framing_err, rx_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver status handling
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_clear_framing_err <= 1'b0;
      overrun_sticky       <= 1'b0;
    end else begin
      // Clear the receiver's sticky error once it has been stored with a byte.
      rx_clear_framing_err <= push & rx_framing_err;
      if (rx_overrun) begin
        overrun_sticky <= 1'b1;
      end else if (overrun_clear) begin
        overrun_sticky <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Character timeout
  // ---------------------------------------------------------------------------
`ifdef RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (push || pop || flush || empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMO_C) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign rx_timeout = ~empty & (idle_cnt == TMO_C);
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_data_valid;
  logic          rx_framing_err;
  logic          rx_overrun;
  logic          rx_host_ready;
  logic          rx_clear_framing_err;
  logic          flush;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_ferr;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          almost_full;
  logic          overrun_sticky;
  logic          overrun_clear;
  logic          rx_timeout;

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .AFULL_LEVEL    (AFULL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_data              (rx_data),
    .rx_data_valid        (rx_data_valid),
    .rx_framing_err       (rx_framing_err),
    .rx_overrun           (rx_overrun),
    .rx_host_ready        (rx_host_ready),
    .rx_clear_framing_err (rx_clear_framing_err),
    .flush                (flush),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rd_ferr              (rd_ferr),
    .rd_valid             (rd_valid),
    .count                (count),
    .full                 (full),
    .almost_full          (almost_full),
    .overrun_sticky       (overrun_sticky),
    .overrun_clear        (overrun_clear),
    .rx_timeout           (rx_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {ferr,data} entries plus status bits.
  logic [8:0] q[$];
  logic       sticky_m = 1'b0;
  logic       clr_m    = 1'b0;
  int         cyc      = 0;
  int         last_act = 0;   // clock edge at which the buffer last saw activity

  function automatic logic tmo_exp();
`ifdef RX_FIFO_TIMEOUT_EN
    return (q.size() != 0) && ((cyc - last_act) >= TMO);
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock from a negedge to the next, updating the model from the
  // inputs currently applied.
  task automatic step();
    bit         pu;
    bit         po;
    logic [8:0] e;
    pu = rx_data_valid && !flush && (q.size() != DEPTH);
    po = rd_en && !flush && (q.size() != 0);
    e  = {rx_framing_err, rx_data};
    if (pu || po || flush || q.size() == 0) last_act = cyc + 1;
    @(posedge clk);
    cyc++;
    if (flush) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(e);
    end
    clr_m = pu && e[8];
    if (rx_overrun) sticky_m = 1'b1;
    else if (overrun_clear) sticky_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rx_data = '0; rx_data_valid = 0; rx_framing_err = 0; rx_overrun = 0;
    flush = 0; rd_en = 0; overrun_clear = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({count, rd_valid, full, almost_full, overrun_sticky, rx_clear_framing_err, rx_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_flags: got count=%0d v=%b f=%b af=%b ov=%b clr=%b to=%b want all 0",
               count, rd_valid, full, almost_full, overrun_sticky, rx_clear_framing_err, rx_timeout);
    end
    checks++;
    if (rd_data !== 8'h00 || rd_ferr !== 1'b0 || rx_host_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_port: got data=%h ferr=%b hr=%b want 00 0 1", rd_data, rd_ferr, rx_host_ready);
    end
    rst = 1'b0;
    q.delete(); sticky_m = 0; clr_m = 0; cyc = 0; last_act = 0;
    step();
  endtask

  task automatic test_push_ferr();
    rx_data = 8'hA5; rx_data_valid = 1; rx_framing_err = 0;
    step();
    rx_data_valid = 0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_ferr !== 1'b0 || count !== CW'(1) || rx_clear_framing_err !== 1'b0) begin
      errors++;
      $display("FAIL push_a5: got v=%b d=%h fe=%b c=%0d clr=%b want 1 a5 0 1 0",
               rd_valid, rd_data, rd_ferr, count, rx_clear_framing_err);
    end
    rx_data = 8'h3C; rx_data_valid = 1; rx_framing_err = 1;
    step();
    rx_data_valid = 0; rx_framing_err = 0;
    checks++;
    if (rx_clear_framing_err !== 1'b1 || count !== CW'(2) || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL clr_pulse: got clr=%b c=%0d d=%h want 1 2 a5", rx_clear_framing_err, count, rd_data);
    end
    rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (rx_clear_framing_err !== 1'b0 || rd_data !== 8'h3C || rd_ferr !== 1'b1) begin
      errors++;
      $display("FAIL ferr_entry: got clr=%b d=%h fe=%b want 0 3c 1", rx_clear_framing_err, rd_data, rd_ferr);
    end
    rd_en = 1;
    step();
    rd_en = 1;   // rd_en while empty must be ignored
    step();
    rd_en = 0;
    checks++;
    if (count !== '0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_ferr !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got c=%0d v=%b d=%h fe=%b want 0 0 00 0", count, rd_valid, rd_data, rd_ferr);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      rx_data = 8'(i); rx_data_valid = 1; rx_framing_err = 0;
      #1;
      checks++;
      if (rx_host_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b want 1", i, rx_host_ready);
      end
      step();
      checks++;
      if (count !== CW'(i + 1) || almost_full !== ((i + 1) >= AFULL) || full !== ((i + 1) == DEPTH)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got c=%0d af=%b f=%b want %0d %b %b",
                 i, count, almost_full, full, i + 1, (i + 1) >= AFULL, (i + 1) == DEPTH);
      end
    end
    rx_data = 8'h10; rx_data_valid = 1;
    #1;
    checks++;
    if (rx_host_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", rx_host_ready);
    end
    step();
    rd_en = 1;
    checks++;
    if (count !== CW'(DEPTH) || rd_data !== 8'h00) begin
      errors++; $display("FAIL full_hold: got c=%0d d=%h want %0d 00", count, rd_data, DEPTH);
    end
    step();   // pop only; the held byte cannot enter while full
    rd_en = 0;
    checks++;
    if (count !== CW'(DEPTH - 1) || full !== 1'b0 || rx_host_ready !== 1'b1) begin
      errors++; $display("FAIL pop_while_full: got c=%0d f=%b hr=%b want %0d 0 1", count, full, rx_host_ready, DEPTH - 1);
    end
    step();
    rx_data_valid = 0;
    checks++;
    if (count !== CW'(DEPTH) || full !== 1'b1) begin
      errors++; $display("FAIL byte17_accept: got c=%0d f=%b want %0d 1", count, full, DEPTH);
    end
    for (int j = 1; j <= DEPTH; j++) begin
      rd_en = 1;
      checks++;
      if (rd_data !== 8'(j)) begin
        errors++; $display("FAIL drain_order[%0d]: got %h want %h", j, rd_data, 8'(j));
      end
      step();
    end
    rd_en = 0;
    checks++;
    if (rd_valid !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL drain_done: got v=%b c=%0d want 0 0", rd_valid, count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'($urandom); rx_framing_err = 1'($urandom); rx_data_valid = 1;
      step();
    end
    rx_data = 8'h77; rx_framing_err = 0; rd_en = 1;
    step();
    checks++;
    if (count !== CW'(5) || rd_data !== q[0][7:0] || rd_ferr !== q[0][8]) begin
      errors++;
      $display("FAIL push_pop_same: got c=%0d d=%h fe=%b want 5 %h %b", count, rd_data, rd_ferr, q[0][7:0], q[0][8]);
    end
    flush = 1; rd_en = 1; rx_data_valid = 1; rx_data = 8'h99;
    #1;
    checks++;
    if (rx_host_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", rx_host_ready);
    end
    step();
    flush = 0; rd_en = 0; rx_data_valid = 0;
    checks++;
    if (count !== '0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || q.size() != 0) begin
      errors++; $display("FAIL flush_empty: got c=%0d v=%b d=%h want 0 0 00", count, rd_valid, rd_data);
    end
    step();
    checks++;
    if (count !== '0) begin
      errors++; $display("FAIL flush_no_accept: got c=%0d want 0", count);
    end
  endtask

  task automatic test_overrun();
    rx_overrun = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (overrun_sticky !== 1'b1) begin
        errors++; $display("FAIL ovr_set[%0d]: got %b want 1", i, overrun_sticky);
      end
    end
    overrun_clear = 1;
    step();
    checks++;
    if (overrun_sticky !== 1'b1) begin
      errors++; $display("FAIL ovr_set_wins: got %b want 1", overrun_sticky);
    end
    rx_overrun = 0;
    step();
    overrun_clear = 0;
    checks++;
    if (overrun_sticky !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b want 0", overrun_sticky);
    end
  endtask

  task automatic test_timeout();
    rx_data = 8'h42; rx_data_valid = 1;
    step();
    rx_data_valid = 0;
    for (int k = 1; k <= TMO + 4; k++) begin
      step();
      checks++;
`ifdef RX_FIFO_TIMEOUT_EN
      if (rx_timeout !== (k >= TMO)) begin
        errors++; $display("FAIL timeout_idle[%0d]: got %b want %b", k, rx_timeout, k >= TMO);
      end
`else
      if (rx_timeout !== 1'b0) begin
        errors++; $display("FAIL timeout_off[%0d]: got %b want 0", k, rx_timeout);
      end
`endif
    end
    rd_en = 1;
    step();
    rd_en = 0;
    checks++;
    if (rx_timeout !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL timeout_pop: got to=%b c=%0d want 0 0", rx_timeout, count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      bit fill_phase;
      fill_phase     = ((n / 100) % 2) == 0;
      rx_data        = 8'($urandom);
      rx_framing_err = ($urandom_range(0, 3) == 0);
      rx_data_valid  = fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      rd_en          = fill_phase ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      flush          = ($urandom_range(0, 49) == 0);
      rx_overrun     = ($urandom_range(0, 19) == 0);
      overrun_clear  = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (rx_host_ready !== ((q.size() != DEPTH) && !flush)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, rx_host_ready, (q.size() != DEPTH) && !flush);
      end
      step();
      checks++;
      if (count !== CW'(q.size()) || rd_valid !== (q.size() != 0) ||
          full !== (q.size() == DEPTH) || almost_full !== (q.size() >= AFULL)) begin
        errors++;
        $display("FAIL rnd_occ[%0d]: got c=%0d v=%b f=%b af=%b want c=%0d", n, count, rd_valid, full, almost_full, q.size());
      end
      checks++;
      if ((q.size() != 0 && (rd_data !== q[0][7:0] || rd_ferr !== q[0][8])) ||
          (q.size() == 0 && (rd_data !== 8'h00 || rd_ferr !== 1'b0))) begin
        errors++;
        $display("FAIL rnd_head[%0d]: got d=%h fe=%b want %h", n, rd_data, rd_ferr, (q.size() != 0) ? q[0] : 9'h000);
      end
      checks++;
      if (rx_clear_framing_err !== clr_m || overrun_sticky !== sticky_m || rx_timeout !== tmo_exp()) begin
        errors++;
        $display("FAIL rnd_status[%0d]: got clr=%b ov=%b to=%b want %b %b %b",
                 n, rx_clear_framing_err, overrun_sticky, rx_timeout, clr_m, sticky_m, tmo_exp());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_push_ferr();
    test_full();
    test_flush();
    test_overrun();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
